logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the CPU datapath; the vector successor of the single-bit not/and/or/xor gates.
- Applies one of eight bitwise functions across WIDTH-bit operands and registers the result with status flags.
- Uses a valid/ready handshake on both sides, with a two-entry output buffer (main register plus skid) so it sustains one operation per cycle under back-pressure.
- Sits between operand fetch and the ALU result mux.

---
 rtl/logic_unit_pipe.sv | 131 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight two-operand functions with result flags,
// valid/ready on both sides and a main+skid output buffer for full throughput.
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0]       f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (f)
      OP_NOT:  return ~x;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NAND: return ~(x & y);
      OP_NOR:  return ~(x | y);
      OP_XNOR: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  logic [WIDTH-1:0] fn_res;
  logic             fn_zero, fn_par;
  logic             accept, xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, parity_q, parity_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_res_q, skid_res_d;
  logic             skid_zero_q, skid_zero_d, skid_par_q, skid_par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign fn_res  = logic_fn(op, a, b);
  assign fn_zero = (fn_res == '0);
  assign fn_par  = ^fn_res;

  // in_ready is a pure function of state (and reset), never of out_ready.
  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    zero_d       = zero_q;
    parity_d     = parity_q;
    skid_valid_d = skid_valid_q;
    skid_res_d   = skid_res_q;
    skid_zero_d  = skid_zero_q;
    skid_par_d   = skid_par_q;
    cnt_d        = xfer ? cnt_q + 1'b1 : cnt_q;

    if (skid_valid_q && (xfer || !out_valid_q)) begin
      result_d     = skid_res_q;
      zero_d       = skid_zero_q;
      parity_d     = skid_par_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || xfer)) begin
      result_d    = fn_res;
      zero_d      = fn_zero;
      parity_d    = fn_par;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    // Main is held by a stalled consumer: park the new result in the skid.
    if (accept && out_valid_q && !out_ready) begin
      skid_res_d   = fn_res;
      skid_zero_d  = fn_zero;
      skid_par_d   = fn_par;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      parity_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_res_q   <= '0;
      skid_zero_q  <= 1'b0;
      skid_par_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      parity_q     <= parity_d;
      skid_valid_q <= skid_valid_d;
      skid_res_q   <= skid_res_d;
      skid_zero_q  <= skid_zero_d;
      skid_par_q   <= skid_par_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised bench for logic_unit_pipe (WIDTH=8, CNT_W=4) with an
// in-order scoreboard fed at input handshakes and drained at output handshakes.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       zero;
  logic       parity;
  logic [3:0] op_count;

  int         checks = 0;
  int         failures = 0;
  int         acc_count = 0;
  logic [3:0] model_cnt = 4'd0;
  logic [9:0] exp_next = 10'd0;   // {parity, zero, result}
  logic [9:0] exp_q[$];
  logic [9:0] dir_tbl[8];

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [9:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    case (o)
      3'd0: r = ~x;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = ~(x & y);
      3'd5: r = ~(x | y);
      3'd6: r = ~(x ^ y);
      default: r = x;
    endcase
    return {^r, (r == 8'h00), r};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      check("in_ready_occ", 32'(in_ready), 32'(exp_q.size() < 2));
      check("op_count", 32'(op_count), 32'(model_cnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e[7:0]));
          check("zero", 32'(zero), 32'(e[8]));
          check("parity", 32'(parity), 32'(e[9]));
        end
        model_cnt = model_cnt + 4'd1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_next);
        acc_count++;
      end
    end
  end

  // Present one op and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [9:0] e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; op = o; a = av; b = bv; exp_next = e;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_cnt = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    dir_tbl = '{10'h00F, 10'h030, 10'h0FC, 10'h0CC, 10'h0CF, 10'h003, 10'h033, 10'h0F0};

    #2;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
    check("rst_parity", 32'(parity), 32'(0));
    check("rst_op_count", 32'(op_count), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All eight functions back-to-back on a=F0, b=3C.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 3'(i); a = 8'hF0; b = 8'h3C; exp_next = dir_tbl[i];
      @(negedge clk);
      if (i > 0) check("dir_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("dir_out_valid_last", 32'(out_valid), 32'(1));
    drain();

    // Flag corner cases; result/flags hold after the final transfer.
    send(3'd3, 8'h55, 8'h55, {1'b0, 1'b1, 8'h00});
    send(3'd1, 8'h07, 8'hFF, {1'b1, 1'b0, 8'h07});
    drain();
    check("hold_result", 32'(result), 32'(8'h07));
    check("hold_zero", 32'(zero), 32'(0));
    check("hold_parity", 32'(parity), 32'(1));

    // Back-pressure: A in main, B in skid, C held by the source.
    do_reset();
    out_ready = 1'b0;
    send(3'd1, 8'hF0, 8'h3C, {1'b0, 1'b0, 8'h30});
    send(3'd2, 8'h0F, 8'h11, {1'b1, 1'b0, 8'h1F});
    in_valid = 1'b1; op = 3'd3; a = 8'hAA; b = 8'hAA; exp_next = {1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_stable_result", 32'(result), 32'(8'h30));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3'd3, 8'hAA, 8'hAA, {1'b0, 1'b1, 8'h00});
    drain();
    check("bp_op_count", 32'(op_count), 32'(3));

    // Counter wrap at 2^CNT_W.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(3'd7, 8'(i), 8'h00, model(3'd7, 8'(i), 8'h00));
    drain();
    check("cnt_wrap16", 32'(op_count), 32'(0));
    send(3'd0, 8'hFF, 8'h00, {1'b0, 1'b1, 8'h00});
    drain();
    check("cnt_after17", 32'(op_count), 32'(1));

    // Random traffic on both sides.
    acc_count = 0;
    n = 0;
    while (acc_count < 10000 && n < 60000) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      op = 3'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      exp_next = model(op, a, b);
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_count < 10000) check("rand_timeout", 32'(acc_count), 32'(10000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Async reset with both entries full.
    if (model_cnt == 4'd0) begin
      send(3'd7, 8'h81, 8'h00, {1'b0, 1'b0, 8'h81});
      drain();
    end
    out_ready = 1'b0;
    send(3'd7, 8'h5A, 8'h00, {1'b0, 1'b0, 8'h5A});
    send(3'd0, 8'h00, 8'h00, {1'b0, 1'b0, 8'hFF});
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'(0));
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 4'd0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_result", 32'(result), 32'(0));
    check("arst_op_count", 32'(op_count), 32'(0));
    check("arst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
